ref_clk_sel_sequencer: RTL and testbench

Break-before-make controller for the reference-clock divider transmission gates ({32,64,128,256,512} enables).
- Accepts ratio-change requests via valid/ready.
- Opens all tgates for a programmable dead time, closes the selected tgate, then holds a settle window before signalling completion.
- Ensures two divided clocks are never shorted together and that downstream logic never sees a glitchy ref clock mid-switch.

---
 rtl/ref_clk_sel_sequencer_pkg.sv | 36 +++
 rtl/ref_clk_sel_sequencer_if.sv | 21 ++
 rtl/ref_clk_sel_sequencer_timer.sv | 34 +++
 rtl/ref_clk_sel_sequencer.sv | 141 ++++++++++++++
 tb/tb_ref_clk_sel_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ref_clk_sel_sequencer_pkg.sv
// Shared types, defaults and code helpers for the reference-clock select sequencer.
// Code mapping: 0=/512 (bit0) ... 4=/32 (bit4); codes 5-7 are invalid.
package ref_clk_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BREAK  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BREAK  = ST_BREAK,
    SETTLE = ST_SETTLE
  } state_t;

  localparam logic [4:0] TGATE_DEFAULT = 5'b00010;
  localparam logic [2:0] CODE_DEFAULT  = 3'd1;
  localparam logic [2:0] CODE_MAX      = 3'd4;

  function automatic logic [4:0] code_to_onehot(input logic [2:0] code);
    logic [4:0] oh;
    case (code)
      3'd0:    oh = 5'b00001;
      3'd1:    oh = 5'b00010;
      3'd2:    oh = 5'b00100;
      3'd3:    oh = 5'b01000;
      3'd4:    oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

  function automatic logic code_valid(input logic [2:0] code);
    return (code <= CODE_MAX);
  endfunction

endpackage

// File: rtl/ref_clk_sel_sequencer_if.sv
// Request handshake and status bundle between a ratio requester and the sequencer.
interface ref_clk_sel_sequencer_if;
  logic       sel_valid;
  logic [2:0] sel_code;
  logic       sel_ready;
  logic [4:0] tgate_control;
  logic [2:0] cur_code;
  logic       busy;
  logic       switch_done;
  logic       sel_err;

  modport master (
    output sel_valid, sel_code,
    input  sel_ready, tgate_control, cur_code, busy, switch_done, sel_err
  );

  modport slave (
    input  sel_valid, sel_code,
    output sel_ready, tgate_control, cur_code, busy, switch_done, sel_err
  );
endinterface

// File: rtl/ref_clk_sel_sequencer_timer.sv
// Loadable down-counter that parks at zero; zero flag is taken straight from the register.
module ref_clk_sel_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ref_clk_sel_sequencer.sv
// Break-before-make sequencer for the ref-clock divider tgates: open all, close the new one, settle.
// Optional macro REF_CLK_SEL_LOCK_EN adds sel_lock, which blocks new requests while high.
module ref_clk_sel_sequencer
  import ref_clk_pkg::*;
#(
  parameter int BREAK_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ref_clk_sel_sequencer_if.slave sel_if
`ifdef REF_CLK_SEL_LOCK_EN
  ,
  input  logic                   sel_lock
`endif
);

  localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] tgate_control_q, tgate_control_d;
  logic [2:0] cur_code_q, cur_code_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic       sel_ready_q, sel_ready_d;
  logic       busy_q, busy_d;
  logic       switch_done_q, switch_done_d;
  logic       sel_err_q, sel_err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;
  logic             lock_blk;
  logic             accept;

`ifdef REF_CLK_SEL_LOCK_EN
  assign lock_blk = sel_lock;
`else
  assign lock_blk = 1'b0;
`endif

  // The live lock also gates accept so a lock raised while ready is already high takes effect at once.
  assign accept = sel_if.sel_valid && sel_ready_q && !lock_blk;

  ref_clk_sel_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d         = state_q;
    tgate_control_d = tgate_control_q;
    cur_code_d      = cur_code_q;
    pend_code_d     = pend_code_q;
    switch_done_d   = 1'b0;
    sel_err_d       = 1'b0;
    tmr_load        = 1'b0;
    tmr_load_val    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!code_valid(sel_if.sel_code)) begin
            sel_err_d = 1'b1;
          end else if (sel_if.sel_code == cur_code_q) begin
            switch_done_d = 1'b1;
          end else begin
            pend_code_d     = sel_if.sel_code;
            tgate_control_d = '0;
            tmr_load        = 1'b1;
            tmr_load_val    = BREAK_LOAD;
            state_d         = BREAK;
          end
        end
      end
      BREAK: begin
        if (tmr_zero) begin
          tgate_control_d = code_to_onehot(pend_code_q);
          cur_code_d      = pend_code_q;
          tmr_load        = 1'b1;
          tmr_load_val    = SETTLE_LOAD;
          state_d         = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          switch_done_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sel_ready_d = (state_d == IDLE) && !lock_blk;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      tgate_control_q <= TGATE_DEFAULT;
      cur_code_q      <= CODE_DEFAULT;
      sel_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      switch_done_q   <= 1'b0;
      sel_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgate_control_q <= tgate_control_d;
      cur_code_q      <= cur_code_d;
      sel_ready_q     <= sel_ready_d;
      busy_q          <= busy_d;
      switch_done_q   <= switch_done_d;
      sel_err_q       <= sel_err_d;
    end
  end

  // Target code is datapath-only; it is always written before BREAK reads it.
  always_ff @(posedge clk) begin
    pend_code_q <= pend_code_d;
  end

  assign sel_if.sel_ready     = sel_ready_q;
  assign sel_if.tgate_control = tgate_control_q;
  assign sel_if.cur_code      = cur_code_q;
  assign sel_if.busy          = busy_q;
  assign sel_if.switch_done   = switch_done_q;
  assign sel_if.sel_err       = sel_err_q;

  a_tgate_safe : assert property (@(posedge clk) disable iff (rst)
    (state_q == BREAK) ? (tgate_control_q == 5'b00000) : $onehot(tgate_control_q));

endmodule

// File: tb/tb_ref_clk_sel_sequencer.sv
// Bench for ref_clk_sel_sequencer: directed scenarios plus random traffic against a cycle-level model.
module tb_ref_clk_sel_sequencer;

  localparam int B = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_lock = 1'b0;

  ref_clk_sel_sequencer_if sel_if ();

  ref_clk_sel_sequencer #(
    .BREAK_CYCLES  (B),
    .SETTLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_if   (sel_if)
`ifdef REF_CLK_SEL_LOCK_EN
    ,
    .sel_lock (sel_lock)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: request kind, code, and edges elapsed since acceptance.
  localparam int K_NONE = 0, K_ERR = 1, K_SAME = 2, K_SW = 3;
  int       m_kind  = K_NONE;
  int       m_since = -1;
  int       m_cur   = 1;
  int       m_old   = 1;
  int       m_code  = 0;
  bit       m_acc   = 0;
  bit       e_ready = 0;
  bit       e_busy, e_done, e_err;
  bit [4:0] e_tg;
  bit [2:0] e_cur;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit idle;
    @(posedge clk);
    m_acc = 0;
    if (rst) begin
      m_cur = 1; m_since = -1; m_kind = K_NONE;
    end else begin
      m_acc = sel_if.sel_valid && e_ready && !sel_lock;
      if (m_acc) begin
        m_since = 0;
        m_code  = int'(sel_if.sel_code);
        if (m_code > 4)           m_kind = K_ERR;
        else if (m_code == m_cur) m_kind = K_SAME;
        else begin m_kind = K_SW; m_old = m_cur; end
      end else if (m_since >= 0 && m_since < 1000) begin
        m_since++;
      end
      if (m_kind == K_SW && m_since == B) m_cur = m_code;
    end
    idle = 1; e_busy = 0; e_done = 0; e_err = 0;
    e_cur = 3'(m_cur);
    e_tg  = 5'(5'd1 << m_cur);
    if (!rst) begin
      if (m_kind == K_ERR  && m_since == 0) e_err  = 1;
      if (m_kind == K_SAME && m_since == 0) e_done = 1;
      if (m_kind == K_SW) begin
        if (m_since < B) begin
          e_tg = 5'd0; e_cur = 3'(m_old); e_busy = 1; idle = 0;
        end else if (m_since < B + S) begin
          e_busy = 1; idle = 0;
        end else if (m_since == B + S) begin
          e_done = 1;
        end
      end
    end
    e_ready = !rst && idle && !sel_lock;
    #1;
    chk("tgate_control", {3'd0, sel_if.tgate_control}, {3'd0, e_tg});
    chk("cur_code",      {5'd0, sel_if.cur_code},      {5'd0, e_cur});
    chk("sel_ready",     {7'd0, sel_if.sel_ready},     {7'd0, e_ready});
    chk("busy",          {7'd0, sel_if.busy},          {7'd0, e_busy});
    chk("switch_done",   {7'd0, sel_if.switch_done},   {7'd0, e_done});
    chk("sel_err",       {7'd0, sel_if.sel_err},       {7'd0, e_err});
  endtask

  task automatic req(input logic [2:0] c);
    int n = 0;
    while (sel_if.sel_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk("req_ready_wait", {7'd0, sel_if.sel_ready}, 8'd1);
    sel_if.sel_valid = 1'b1;
    sel_if.sel_code  = c;
    step();
    sel_if.sel_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int zc;
    int lat;
    sel_if.sel_valid = 1'b0;
    sel_if.sel_code  = 3'd0;

    // Reset held, then released.
    repeat (3) step();
    chk("rst_tgate", {3'd0, sel_if.tgate_control}, 8'h02);
    chk("rst_ready", {7'd0, sel_if.sel_ready}, 8'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", {7'd0, sel_if.sel_ready}, 8'd1);
    chk("idle_cur",   {5'd0, sel_if.cur_code},  8'd1);
    repeat (2) step();

    // Same code: immediate completion, no break.
    req(3'd1);
    chk("same_done",  {7'd0, sel_if.switch_done}, 8'd1);
    chk("same_tgate", {3'd0, sel_if.tgate_control}, 8'h02);
    repeat (2) step();

    // Invalid code: error pulse only.
    req(3'd6);
    chk("inv_err",  {7'd0, sel_if.sel_err},     8'd1);
    chk("inv_done", {7'd0, sel_if.switch_done}, 8'd0);
    repeat (2) step();

    // Full switch to code 4; measure zero window and completion latency.
    req(3'd4);
    zc  = (sel_if.tgate_control == 5'd0) ? 1 : 0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (sel_if.tgate_control == 5'd0) zc++;
      if (sel_if.switch_done === 1'b1 && lat == 0) lat = k;
    end
    chk("break_window",   8'(zc),  8'(B));
    chk("done_latency",   8'(lat), 8'(B + S + 1));
    chk("sw4_tgate",      {3'd0, sel_if.tgate_control}, 8'h10);
    chk("sw4_cur",        {5'd0, sel_if.cur_code},      8'd4);

    // Request held while busy is accepted on return to IDLE.
    req(3'd2);
    sel_if.sel_valid = 1'b1;
    sel_if.sel_code  = 3'd3;
    repeat (B + S + 2) step();
    sel_if.sel_valid = 1'b0;
    repeat (B + S + 2) step();
    chk("held_cur", {5'd0, sel_if.cur_code}, 8'd3);

    // Reset during BREAK aborts to defaults.
    req(3'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tgate", {3'd0, sel_if.tgate_control}, 8'h02);
    chk("abort_busy",  {7'd0, sel_if.busy},          8'd0);
    repeat (B + S + 2) step();
    chk("abort_cur",   {5'd0, sel_if.cur_code},      8'd1);

`ifdef REF_CLK_SEL_LOCK_EN
    sel_lock = 1'b1;
    step();
    sel_if.sel_valid = 1'b1;
    sel_if.sel_code  = 3'd2;
    repeat (10) step();
    chk("lock_blocks", {7'd0, sel_if.busy}, 8'd0);
    sel_lock = 1'b0;
    zc = 0;
    while (!m_acc && zc < 20) begin
      step();
      zc++;
    end
    sel_if.sel_valid = 1'b0;
    chk("lock_accept_busy", {7'd0, sel_if.busy}, 8'd1);
    repeat (B + S + 2) step();
    chk("lock_tgate", {3'd0, sel_if.tgate_control}, 8'h04);
`endif

    // Random traffic including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst              = ($urandom_range(0, 120) == 0);
      sel_if.sel_valid = ($urandom_range(0, 3) == 0);
      sel_if.sel_code  = 3'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    sel_if.sel_valid = 1'b0;
    repeat (B + S + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
